// File: rtl/seq_mul_unit_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encodings,
// the default operand width and the opcode that selects the sequential multiply.
package seq_mul_unit_pkg;

  localparam int SMUL_DEFAULT_WIDTH = 16;

  // Decoder opcode that routes an instruction to the sequential multiplier
  localparam logic [3:0] OP_SMUL = 4'hD;

  typedef enum logic [1:0] {
    SMUL_IDLE = 2'd0,
    SMUL_RUN  = 2'd1,
    SMUL_DONE = 2'd2
  } smul_state_t;

endpackage

// File: rtl/seq_mul_unit_if.sv
// Request/response bundle between the ALU decoder (master) and the multiplier (slave).
// signed_op is only meaningful when SEQ_MUL_SIGNED_EN is defined.
interface seq_mul_unit_if import seq_mul_unit_pkg::*; #(
  parameter int WIDTH = SMUL_DEFAULT_WIDTH
);
  logic               start;
  logic               signed_op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (output start, signed_op, a, b, input busy, done, result);
  modport slave  (input start, signed_op, a, b, output busy, done, result);
endinterface

// File: rtl/seq_mul_datapath.sv
// Shift-add datapath: multiplicand/multiplier shift registers, accumulator and
// result register. SEQ_MUL_SIGNED_EN adds magnitude capture and a final negate.
module seq_mul_datapath import seq_mul_unit_pkg::*; #(
  parameter int WIDTH = SMUL_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               fin,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               signed_op,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

`ifdef SEQ_MUL_SIGNED_EN
  logic neg;
  logic neg_in;

  // Most-negative input wraps to itself, which read as unsigned is its true magnitude
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic en);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return (en && v[WIDTH-1]) ? n : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] v,
                                                    input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  assign mag_a   = magnitude(a, signed_op);
  assign mag_b   = magnitude(b, signed_op);
  assign neg_in  = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
  assign product = apply_sign(acc_next, neg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    neg <= 1'b0;
    else if (load) neg <= neg_in;
  end
`else
  assign mag_a   = a;
  assign mag_b   = b;
  assign product = acc_next;
`endif

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  // The last iteration's sum goes straight into result, so it is valid in the done cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      result <= '0;
    end else begin
      if (load) begin
        mcand  <= {{WIDTH{1'b0}}, mag_a};
        mplier <= mag_b;
        acc    <= '0;
      end else if (step) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (fin) result <= product;
    end
  end

endmodule

// File: rtl/seq_mul_unit.sv
// Iterative radix-2 shift-add multiplier: WIDTH+1 cycles per product, start accepted
// in IDLE or DONE. Signed operation is built only when SEQ_MUL_SIGNED_EN is defined.
module seq_mul_unit import seq_mul_unit_pkg::*; #(
  parameter int WIDTH = SMUL_DEFAULT_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mul_unit_if.slave bus
);

  smul_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic             busy;
  logic             done;
  logic             accept;
  logic             step;
  logic             last;

  assign accept = bus.start && (state != SMUL_RUN);
  assign step   = (state == SMUL_RUN);
  assign last   = step && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SMUL_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        SMUL_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            state <= SMUL_RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SMUL_RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= SMUL_DONE;
            done  <= 1'b1;
          end
        end
        SMUL_DONE: begin
          done <= 1'b0;
          if (accept) begin
            state <= SMUL_RUN;
            cnt   <= '0;
            busy  <= 1'b1;
          end else begin
            state <= SMUL_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= SMUL_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;

  seq_mul_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .step      (step),
    .fin       (last),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_op (bus.signed_op),
`endif
    .a         (bus.a),
    .b         (bus.b),
    .result    (bus.result)
  );

endmodule
